// File: rtl/n1_sbus_mem.sv
// Pipelined stack-bus target with separate PS/RS banks, a fixed response latency
// and bench-controlled stall, retry and error injection.
module n1_sbus_mem #(
    parameter int ADR_WIDTH = 12,
    parameter int DAT_WIDTH = 16,
    parameter int LATENCY   = 1
) (
    input  logic                 clk_i,
    input  logic                 sync_rst_i,
    input  logic                 sbus_cyc_i,
    input  logic                 sbus_stb_i,
    input  logic                 sbus_we_i,
    input  logic [ADR_WIDTH-1:0] sbus_adr_i,
    input  logic [DAT_WIDTH-1:0] sbus_dat_i,
    input  logic                 sbus_tga_ps_i,
    input  logic                 sbus_tga_rs_i,
    output logic                 sbus_ack_o,
    output logic                 sbus_err_o,
    output logic                 sbus_rty_o,
    output logic                 sbus_stall_o,
    output logic [DAT_WIDTH-1:0] sbus_dat_o,
    input  logic                 inj_stall_i,
    input  logic                 inj_rty_i,
    input  logic                 inj_err_i,
    output logic [3:0]           outst_o
);

    typedef enum logic [1:0] {
        KIND_OK  = 2'd0,
        KIND_RTY = 2'd1,
        KIND_ERR = 2'd2
    } kind_t;

    logic [DAT_WIDTH-1:0] mem_ps [2**ADR_WIDTH];
    logic [DAT_WIDTH-1:0] mem_rs [2**ADR_WIDTH];

    logic                 accept;
    kind_t                acc_kind;
    logic [DAT_WIDTH-1:0] rd_word;
    logic                 resp_vld;

    logic                 pipe_vld  [LATENCY];
    kind_t                pipe_kind [LATENCY];
    logic [DAT_WIDTH-1:0] pipe_dat  [LATENCY];

    assign sbus_stall_o = inj_stall_i;
    assign accept       = sbus_cyc_i & sbus_stb_i & ~inj_stall_i;
    assign rd_word      = sbus_tga_rs_i ? mem_rs[sbus_adr_i] : mem_ps[sbus_adr_i];

    // An ambiguous bank select is a bus error and outranks any injected retry.
    always_comb begin
        acc_kind = KIND_OK;
        if ((sbus_tga_ps_i == sbus_tga_rs_i) || inj_err_i)
            acc_kind = KIND_ERR;
        else if (inj_rty_i)
            acc_kind = KIND_RTY;
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i && accept && (acc_kind == KIND_OK) && sbus_we_i) begin
            if (sbus_tga_rs_i)
                mem_rs[sbus_adr_i] <= sbus_dat_i;
            else
                mem_ps[sbus_adr_i] <= sbus_dat_i;
        end
    end

    // Dropping cyc_i flushes the pipe so aborted requests never respond.
    always_ff @(posedge clk_i) begin
        if (!sync_rst_i || !sbus_cyc_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_kind[i] <= KIND_OK;
                pipe_dat[i]  <= '0;
            end
        end else begin
            pipe_vld[0]  <= accept;
            pipe_kind[0] <= acc_kind;
            pipe_dat[0]  <= (accept && (acc_kind == KIND_OK) && !sbus_we_i) ? rd_word : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_kind[i] <= pipe_kind[i-1];
                pipe_dat[i]  <= pipe_dat[i-1];
            end
        end
    end

    assign resp_vld   = pipe_vld[LATENCY-1];
    assign sbus_ack_o = resp_vld && (pipe_kind[LATENCY-1] == KIND_OK);
    assign sbus_rty_o = resp_vld && (pipe_kind[LATENCY-1] == KIND_RTY);
    assign sbus_err_o = resp_vld && (pipe_kind[LATENCY-1] == KIND_ERR);
    assign sbus_dat_o = sbus_ack_o ? pipe_dat[LATENCY-1] : '0;

    always_ff @(posedge clk_i) begin
        if (!sync_rst_i || !sbus_cyc_i) begin
            outst_o <= 4'd0;
        end else begin
            case ({accept, resp_vld})
                2'b10:   outst_o <= outst_o + 4'd1;
                2'b01:   outst_o <= outst_o - 4'd1;
                default: outst_o <= outst_o;
            endcase
        end
    end

endmodule

// File: tb/tb_n1_sbus_mem.sv
// Directed bench for n1_sbus_mem: three instances (LATENCY 1, 3, 4) share one
// stimulus stream; each step checks the instance whose latency it targets.
module tb_n1_sbus_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [11:0] adr;
    logic [15:0] dat;
    logic        tga_ps, tga_rs;
    logic        inj_stall, inj_rty, inj_err;

    logic        ack1, err1, rty1, stall1;
    logic [15:0] dat1;
    logic [3:0]  outst1;
    logic        ack3, err3, rty3, stall3;
    logic [15:0] dat3;
    logic [3:0]  outst3;
    logic        ack4, err4, rty4, stall4;
    logic [15:0] dat4;
    logic [3:0]  outst4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    n1_sbus_mem #(.ADR_WIDTH(12), .DAT_WIDTH(16), .LATENCY(1)) u1 (
        .clk_i(clk), .sync_rst_i(rst_n), .sbus_cyc_i(cyc), .sbus_stb_i(stb),
        .sbus_we_i(we), .sbus_adr_i(adr), .sbus_dat_i(dat),
        .sbus_tga_ps_i(tga_ps), .sbus_tga_rs_i(tga_rs),
        .sbus_ack_o(ack1), .sbus_err_o(err1), .sbus_rty_o(rty1),
        .sbus_stall_o(stall1), .sbus_dat_o(dat1),
        .inj_stall_i(inj_stall), .inj_rty_i(inj_rty), .inj_err_i(inj_err),
        .outst_o(outst1)
    );

    n1_sbus_mem #(.ADR_WIDTH(12), .DAT_WIDTH(16), .LATENCY(3)) u3 (
        .clk_i(clk), .sync_rst_i(rst_n), .sbus_cyc_i(cyc), .sbus_stb_i(stb),
        .sbus_we_i(we), .sbus_adr_i(adr), .sbus_dat_i(dat),
        .sbus_tga_ps_i(tga_ps), .sbus_tga_rs_i(tga_rs),
        .sbus_ack_o(ack3), .sbus_err_o(err3), .sbus_rty_o(rty3),
        .sbus_stall_o(stall3), .sbus_dat_o(dat3),
        .inj_stall_i(inj_stall), .inj_rty_i(inj_rty), .inj_err_i(inj_err),
        .outst_o(outst3)
    );

    n1_sbus_mem #(.ADR_WIDTH(12), .DAT_WIDTH(16), .LATENCY(4)) u4 (
        .clk_i(clk), .sync_rst_i(rst_n), .sbus_cyc_i(cyc), .sbus_stb_i(stb),
        .sbus_we_i(we), .sbus_adr_i(adr), .sbus_dat_i(dat),
        .sbus_tga_ps_i(tga_ps), .sbus_tga_rs_i(tga_rs),
        .sbus_ack_o(ack4), .sbus_err_o(err4), .sbus_rty_o(rty4),
        .sbus_stall_o(stall4), .sbus_dat_o(dat4),
        .inj_stall_i(inj_stall), .inj_rty_i(inj_rty), .inj_err_i(inj_err),
        .outst_o(outst4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] check %s failed", tag);
        end
    endtask

    // One request presented for exactly one edge, then stb dropped.
    task automatic apply_stimulus(input logic w, input logic [11:0] a, input logic [15:0] d,
                                  input logic ps, input logic rs);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; tga_ps = ps; tga_rs = rs;
        tick();
        stb = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0;
        tga_ps = 1'b0; tga_rs = 1'b0; inj_stall = 1'b1; inj_rty = 1'b0; inj_err = 1'b0;

        tick();
        tick();
        check_output("rst_stall_follows_inj", {31'd0, stall1}, 32'd1);
        check_output("rst_ack", {29'd0, ack1, err1, rty1}, 32'd0);
        check_output("rst_dat", {16'd0, dat1}, 32'd0);
        check_output("rst_outst", {28'd0, outst1}, 32'd0);
        inj_stall = 1'b0;
        #1;
        check_output("rst_stall_low", {31'd0, stall1}, 32'd0);
        rst_n = 1'b1;
        cyc = 1'b1;
        tick();

        apply_stimulus(1'b1, 12'h005, 16'h0000, 1'b0, 1'b1);
        apply_stimulus(1'b1, 12'h010, 16'h0000, 1'b0, 1'b1);
        apply_stimulus(1'b1, 12'h006, 16'h0A0A, 1'b1, 1'b0);
        apply_stimulus(1'b1, 12'hFFF, 16'hCAFE, 1'b1, 1'b0);
        idle(5);

        apply_stimulus(1'b1, 12'h005, 16'hBEEF, 1'b1, 1'b0);
        check_output("t1_wr_ack", {31'd0, ack1}, 32'd1);
        check_output("t1_wr_dat", {16'd0, dat1}, 32'd0);
        check_output("t1_wr_outst", {28'd0, outst1}, 32'd1);
        idle(1);
        check_output("t1_wr_ack_gone", {31'd0, ack1}, 32'd0);
        check_output("t1_outst_back", {28'd0, outst1}, 32'd0);
        apply_stimulus(1'b0, 12'h005, 16'h0000, 1'b1, 1'b0);
        check_output("t1_rd_ps_ack", {31'd0, ack1}, 32'd1);
        check_output("t1_rd_ps_dat", {16'd0, dat1}, 32'h0000BEEF);
        apply_stimulus(1'b0, 12'h005, 16'h0000, 1'b0, 1'b1);
        check_output("t1_rd_rs_ack", {31'd0, ack1}, 32'd1);
        check_output("t1_rd_rs_dat", {16'd0, dat1}, 32'd0);
        apply_stimulus(1'b0, 12'hFFF, 16'h0000, 1'b1, 1'b0);
        check_output("t1_rd_top_dat", {16'd0, dat1}, 32'h0000CAFE);
        idle(5);

        apply_stimulus(1'b0, 12'h005, 16'h0000, 1'b1, 1'b0);
        check_output("t2_outst_1", {28'd0, outst3}, 32'd1);
        check_output("t2_no_ack_0", {31'd0, ack3}, 32'd0);
        apply_stimulus(1'b0, 12'h006, 16'h0000, 1'b1, 1'b0);
        check_output("t2_outst_2", {28'd0, outst3}, 32'd2);
        check_output("t2_no_ack_1", {31'd0, ack3}, 32'd0);
        apply_stimulus(1'b0, 12'h005, 16'h0000, 1'b1, 1'b0);
        check_output("t2_outst_3", {28'd0, outst3}, 32'd3);
        check_output("t2_ack_a", {31'd0, ack3}, 32'd1);
        check_output("t2_dat_a", {16'd0, dat3}, 32'h0000BEEF);
        tick();
        check_output("t2_ack_b", {31'd0, ack3}, 32'd1);
        check_output("t2_dat_b", {16'd0, dat3}, 32'h00000A0A);
        check_output("t2_outst_b", {28'd0, outst3}, 32'd2);
        tick();
        check_output("t2_ack_c", {31'd0, ack3}, 32'd1);
        check_output("t2_dat_c", {16'd0, dat3}, 32'h0000BEEF);
        check_output("t2_outst_c", {28'd0, outst3}, 32'd1);
        tick();
        check_output("t2_ack_done", {31'd0, ack3}, 32'd0);
        check_output("t2_outst_done", {28'd0, outst3}, 32'd0);
        idle(4);

        inj_stall = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 12'h006; tga_ps = 1'b1; tga_rs = 1'b0;
        tick();
        check_output("t3_stall_o", {31'd0, stall1}, 32'd1);
        check_output("t3_outst_s0", {28'd0, outst1}, 32'd0);
        check_output("t3_ack_s0", {31'd0, ack1}, 32'd0);
        tick();
        check_output("t3_outst_s1", {28'd0, outst1}, 32'd0);
        check_output("t3_ack_s1", {31'd0, ack1}, 32'd0);
        inj_stall = 1'b0;
        tick();
        stb = 1'b0;
        check_output("t3_ack", {31'd0, ack1}, 32'd1);
        check_output("t3_dat", {16'd0, dat1}, 32'h00000A0A);
        check_output("t3_outst", {28'd0, outst1}, 32'd1);
        tick();
        check_output("t3_single_ack", {31'd0, ack1}, 32'd0);
        idle(4);

        inj_rty = 1'b1;
        apply_stimulus(1'b1, 12'h010, 16'h1234, 1'b0, 1'b1);
        inj_rty = 1'b0;
        check_output("t4_rty", {31'd0, rty1}, 32'd1);
        check_output("t4_ack_err", {30'd0, ack1, err1}, 32'd0);
        apply_stimulus(1'b0, 12'h010, 16'h0000, 1'b0, 1'b1);
        check_output("t4_rd_ack", {29'd0, ack1, err1, rty1}, 32'd4);
        check_output("t4_rd_dat", {16'd0, dat1}, 32'd0);
        idle(4);

        apply_stimulus(1'b0, 12'h005, 16'h0000, 1'b1, 1'b1);
        check_output("t5_err", {29'd0, ack1, err1, rty1}, 32'd2);
        check_output("t5_dat", {16'd0, dat1}, 32'd0);
        tick();
        check_output("t5_err_once", {31'd0, err1}, 32'd0);
        inj_err = 1'b1; inj_rty = 1'b1;
        apply_stimulus(1'b0, 12'h005, 16'h0000, 1'b1, 1'b0);
        inj_err = 1'b0; inj_rty = 1'b0;
        check_output("t5_err_wins", {29'd0, ack1, err1, rty1}, 32'd2);
        idle(4);

        apply_stimulus(1'b0, 12'h005, 16'h0000, 1'b1, 1'b0);
        apply_stimulus(1'b0, 12'h006, 16'h0000, 1'b1, 1'b0);
        check_output("t6_outst_pre", {28'd0, outst4}, 32'd2);
        cyc = 1'b0;
        tick();
        check_output("t6_outst_abort", {28'd0, outst4}, 32'd0);
        cyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("t6_no_resp", {29'd0, ack4, err4, rty4}, 32'd0);
        end

        apply_stimulus(1'b0, 12'h005, 16'h0000, 1'b1, 1'b0);
        apply_stimulus(1'b0, 12'h006, 16'h0000, 1'b1, 1'b0);
        check_output("t7_outst_pre", {28'd0, outst4}, 32'd2);
        rst_n = 1'b0;
        tick();
        check_output("t7_outst_rst", {28'd0, outst4}, 32'd0);
        check_output("t7_resp_rst", {29'd0, ack4, err4, rty4}, 32'd0);
        check_output("t7_dat_rst", {16'd0, dat4}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("t7_no_resp", {29'd0, ack4, err4, rty4}, 32'd0);
        end
        apply_stimulus(1'b0, 12'h005, 16'h0000, 1'b1, 1'b0);
        check_output("t7_mem_kept", {16'd0, dat1}, 32'h0000BEEF);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
